// File: rtl/hazard_pkg.sv
// hazard_pkg: FSM state type, forward-select codes and forward helper.
// Shared by hazard_controller and forward_unit.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Memory stage wins over Writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rdm,
    input logic       wm,
    input logic [4:0] rdw,
    input logic       ww
  );
    if (wm && rdm != 5'd0 && rdm == rs) return FWD_MEM;
    if (ww && rdw != 5'd0 && rdw == rs) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// forward_unit: combinational operand-forward selects for Execute.
// Pure function of register numbers and write enables; no state.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush FSM with memory-wait timeout.
// Optional HAZARD_PERF_EN adds StallCount/FlushCount counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  localparam int CW_MIN = $clog2(MEM_TIMEOUT + 2);
  localparam int CW = (CW_MIN > 8) ? CW_MIN : 8;
  localparam logic [CW-1:0] TIMEOUT = CW'(MEM_TIMEOUT);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] wait_cnt;
  logic          mem_err;
  logic          mem_hold;
  logic          load_use;
  logic          unused_rsrc;

  assign unused_rsrc = ResultSrcE[1];
  assign MemErr      = mem_err;

  forward_unit u_fwd (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
  );

  // next state and stall/flush decode; reset, memory wait, branch, load-use
  always_comb begin
    state_n  = state;
    mem_hold = 1'b0;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushW   = 1'b0;
    load_use = ResultSrcE[0] && RdE != 5'd0 &&
               (RdE == Rs1D || RdE == Rs2D);
    unique case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_n  = MEM_WAIT;
          mem_hold = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) state_n = RUN;
        else mem_hold = 1'b1;
      end
      default: state_n = RUN;
    endcase
    priority case (1'b1)
      rst: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushW = 1'b1;
      end
      mem_hold: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end
      PCSrcE: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      load_use: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      default: ;
    endcase
  end

  // state register, saturating wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == RUN)
        wait_cnt <= '0;
      else if (!MemReadyM && wait_cnt != TIMEOUT)
        wait_cnt <= wait_cnt + CW'(1);
      if (state == MEM_WAIT && !MemReadyM &&
          (wait_cnt + CW'(1)) >= TIMEOUT)
        mem_err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  // saturating counts of fetch-stall and execute-flush cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && StallCount != 32'hFFFF_FFFF)
        StallCount <= StallCount + 32'd1;
      if (FlushE && FlushCount != 32'hFFFF_FFFF)
        FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255; maximum consecutive MEM_WAIT cycles before the memory-error flag sets.
REQ-002 SHALL have ports, in this order (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
REQ-003 SHALL have decode/execute hazard inputs:
- Rs1D, Rs2D, in, 5 each: source registers in Decode.
- Rs1E, Rs2E, RdE, in, 5 each: execute-stage registers.
- ResultSrcE, in, 2: bit 0 set marks a load in Execute.
- PCSrcE, in, 1: taken branch or jump in Execute.
REQ-004 SHALL have writeback-path inputs:
- RdM, RdW, in, 5 each: destination registers in Memory and Writeback.
- RegWriteM, RegWriteW, in, 1 each: register-write enables.
REQ-005 SHALL have memory handshake inputs:
- MemReqM, in, 1: memory access pending in the Memory stage.
- MemReadyM, in, 1: memory completes this cycle.
REQ-006 SHALL have outputs:
- StallF, StallD, StallE, StallM, out, 1 each: hold the corresponding stage register.
- FlushD, FlushE, FlushW, out, 1 each: clear the corresponding stage register (drives its CLR).
- ForwardAE, ForwardBE, out, 2 each: operand select; 00 = register file, 01 = Writeback, 10 = Memory.
- MemErr, out, 1: sticky memory-timeout flag.

Function
REQ-007 SHALL implement FSM states RUN and MEM_WAIT.
- RUN to MEM_WAIT when MemReqM=1 and MemReadyM=0.
- MEM_WAIT to RUN when MemReadyM=1.
REQ-008 SHALL, in MEM_WAIT and in the RUN cycle that triggers the RUN-to-MEM_WAIT transition:
- assert StallF, StallD, StallE, StallM and FlushW;
- deassert FlushD and FlushE regardless of other hazards.
REQ-009 SHALL, in RUN with no memory wait and PCSrcE=1, assert FlushD and FlushE with no stall; branch flush overrides load-use.
REQ-010 SHALL detect load-use, in RUN with no memory wait and PCSrcE=0, as ResultSrcE[0]=1, RdE!=0 and (RdE==Rs1D or RdE==Rs2D); then assert StallF, StallD and FlushE for that cycle only.
REQ-011 SHALL compute ForwardAE combinationally, independent of state:
- 10 if RegWriteM, RdM!=0 and RdM==Rs1E;
- else 01 if RegWriteW, RdW!=0 and RdW==Rs1E;
- else 00.
ForwardBE SHALL use the same rule with Rs2E; Memory wins when both match.
REQ-012 SHALL keep an 8-bit-minimum wait counter: cleared on entering MEM_WAIT, incremented each MEM_WAIT cycle, saturating at MEM_TIMEOUT.
REQ-013 SHALL set MemErr when the wait counter reaches MEM_TIMEOUT; MemErr stays set until rst; the FSM keeps waiting.
REQ-014 SHALL, when MemReadyM=1 in the same cycle as MemReqM (in RUN), produce no stall.
REQ-015 SHALL hold all stall/flush outputs low when no hazard is present.

Reset
REQ-016 SHALL, on rst=1 at a clk edge, enter RUN, clear the wait counter and MemErr, and clear performance counters if present.
REQ-017 SHALL force all stall outputs low and FlushD, FlushE, FlushW high while rst=1; forward selects remain combinational.
REQ-018 SHALL let reset mid-MEM_WAIT abandon the wait immediately, with no error flagged.

Configuration
REQ-019 SHALL, with macro HAZARD_PERF_EN defined, add 32-bit outputs:
- StallCount: cycles with StallF=1;
- FlushCount: cycles with FlushE=1.
Both SHALL saturate at 0xFFFFFFFF and clear on rst.
REQ-020 SHALL, without HAZARD_PERF_EN, omit those ports and counters entirely; all other behaviour is identical.

Structure
REQ-021 SHALL place in shared package hazard_pkg:
- FSM state typedef (RUN, MEM_WAIT);
- forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10.
REQ-022 SHALL instantiate one sub-module, forward_unit, holding the combinational ForwardAE/ForwardBE logic; stall/flush FSM stays in hazard_controller.

Verification
REQ-023 Load-use: ResultSrcE=01, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for exactly one cycle; the next cycle, with RdE=0 after the bubble, all low.
REQ-024 Branch plus load-use in the same cycle: PCSrcE=1, load with RdE=Rs2D=7 -> FlushD=FlushE=1, StallF=StallD=0.
REQ-025 Forwarding priority: RdM=RdW=3, both RegWrite=1, Rs1E=3 -> ForwardAE=10; RdM=0, RdW=0, Rs1E=0 -> 00.
REQ-026 Memory wait: MemReqM=1, MemReadyM=0 for 4 cycles then 1 -> four stages stalled and FlushW=1 for 4 cycles; RUN on cycle 5; MemErr=0.
REQ-027 Timeout: MEM_TIMEOUT=3, MemReadyM held 0 -> MemErr=1 after the 3rd wait cycle and stays 1 after MemReadyM=1; rst clears it.
REQ-028 Perf (HAZARD_PERF_EN): run REQ-023 then REQ-026 -> StallCount=5, FlushCount=1; rst mid-MEM_WAIT -> counters 0, state RUN.
